// File: rtl/vga_pixel_fetch.sv
// Pixel fetch for a 320x240 RGB332 framebuffer shown 2x2-doubled on a 640x480 scan.
// Optional build macro VGA_PIXEL_FETCH_BORDER_EN forces the outermost visible ring to white.
module vga_pixel_fetch #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_TOTAL    = 800,
    parameter int FB_WIDTH   = 320,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clock_25mhz,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  in_active_area,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_rd_en,
    input  logic [7:0]            fb_data,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] X_RIGHT = 10'(H_ACTIVE - 1);

    function automatic logic [3:0] expand3(input logic [2:0] v);
        return {v, v[2]};
    endfunction

    function automatic logic [3:0] expand2(input logic [1:0] v);
        return {v, v};
    endfunction

    logic [ADDR_WIDTH-1:0] row_base;
    logic                  primed;
    logic                  act_p0, act_p1;
    logic                  hs_p0, hs_p1, vs_p0, vs_p1;
    logic                  fs_p0, fs_p1;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
    logic                  bord_p0, bord_p1;
`endif

    // Row base tracks y[9:1]*FB_WIDTH by accumulation; primed stays low until the first
    // end-of-frame reload so a mid-frame reset release cannot show misaddressed rows.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            row_base <= '0;
            primed   <= 1'b0;
        end else if (x == X_LAST) begin
            if (y == Y_LAST) begin
                row_base <= '0;
                primed   <= 1'b1;
            end else if (y[0] && (y < Y_LAST)) begin
                row_base <= row_base + ADDR_WIDTH'(FB_WIDTH);
            end
        end
    end

    // Stage A: address generation and flag capture
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            act_p0   <= 1'b0;
            hs_p0    <= 1'b1;
            vs_p0    <= 1'b1;
            fs_p0    <= 1'b0;
        end else begin
            if (in_active_area)
                fb_addr <= row_base + ADDR_WIDTH'(x[9:1]);
            fb_rd_en <= in_active_area;
            act_p0   <= in_active_area & primed;
            hs_p0    <= hsync_in;
            vs_p0    <= vsync_in;
            fs_p0    <= (x == 10'd0) && (y == 10'd0);
        end
    end

    // Stage B: RAM access in flight, flags only
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            act_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            fs_p1  <= 1'b0;
        end else begin
            act_p1 <= act_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            fs_p1  <= fs_p0;
        end
    end

`ifdef VGA_PIXEL_FETCH_BORDER_EN
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            bord_p0 <= 1'b0;
            bord_p1 <= 1'b0;
        end else begin
            bord_p0 <= (x == 10'd0) || (x == X_RIGHT) || (y == 10'd0) || (y == Y_LAST);
            bord_p1 <= bord_p0;
        end
    end
`else
    logic unused_right;
    assign unused_right = (x == X_RIGHT);
`endif

    // Stage C: colour expansion and aligned syncs
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_p1;
            vsync       <= vs_p1;
            frame_start <= fs_p1;
            if (!act_p1) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
            end else if (bord_p1) begin
                red   <= 4'hF;
                green <= 4'hF;
                blue  <= 4'hF;
`endif
            end else begin
                red   <= expand3(fb_data[7:5]);
                green <= expand3(fb_data[4:2]);
                blue  <= expand2(fb_data[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: directed scan sequence with random pixel picks, checked
// against a frame-level reference model (address = (y/2)*320 + x/2, 3-cycle alignment).
module tb_vga_pixel_fetch;

    logic        clock_25mhz = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, in_active_area = 1'b0;
    logic [16:0] fb_addr;
    logic        fb_rd_en;
    logic [7:0]  fb_data = 8'h00;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, frame_start;

    int compared = 0;
    int mismatched = 0;
    int ram_mode = 0;
    int fs_seen = 0;

    vga_pixel_fetch dut (
        .clock_25mhz   (clock_25mhz),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .in_active_area(in_active_area),
        .fb_addr       (fb_addr),
        .fb_rd_en      (fb_rd_en),
        .fb_data       (fb_data),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .hsync         (hsync),
        .vsync         (vsync),
        .frame_start   (frame_start)
    );

    always #20 clock_25mhz = ~clock_25mhz;

    function automatic logic [7:0] ram_byte(input int a);
        if (ram_mode == 1) return 8'hE3;
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    // Synchronous-read RAM: data valid one cycle after the address.
    always @(posedge clock_25mhz)
        if (fb_rd_en) fb_data <= ram_byte(int'(fb_addr));

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       primed;
    } entry_t;

    entry_t hist [3];
    bit     primed;
    int     exp_addr;
    bit     addr_known;

    function automatic int widen3(input int v);
        return v * 2 + v / 4;
    endfunction

    function automatic logic [11:0] exp_rgb(input entry_t e);
        int d;
        if (!e.act || !e.primed) return 12'h000;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
        if (e.x == 0 || e.x == 639 || e.y == 0 || e.y == 479) return 12'hFFF;
`endif
        d = int'(ram_byte((int'(e.y) / 2) * 320 + int'(e.x) / 2));
        return {4'(widen3(d / 32)), 4'(widen3((d / 4) % 8)), 4'((d % 4) * 5)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        entry_t idle;
        idle = '{x: 10'd1, y: 10'd1, hs: 1'b1, vs: 1'b1, act: 1'b0, primed: 1'b0};
        for (int i = 0; i < 3; i++) hist[i] = idle;
        primed     = 1'b0;
        exp_addr   = 0;
        addr_known = 1'b1;
    endtask

    // Called at a falling edge: check what the last rising edge produced, then drive the next position.
    task automatic step(input int xi, input int yi);
        entry_t e;
        chk("hsync", 32'(hsync), 32'(hist[2].hs));
        chk("vsync", 32'(vsync), 32'(hist[2].vs));
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb(hist[2])));
        chk("frame_start", 32'(frame_start), 32'(hist[2].x == 0 && hist[2].y == 0));
        if (frame_start === 1'b1) fs_seen++;
        chk("fb_rd_en", 32'(fb_rd_en), 32'(hist[0].act));
        if (hist[0].act) begin
            if (hist[0].primed) begin
                exp_addr   = (int'(hist[0].y) / 2) * 320 + int'(hist[0].x) / 2;
                addr_known = 1'b1;
            end else begin
                addr_known = 1'b0;
            end
        end
        if (addr_known) chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
        if (primed) chk("fb_addr_limit", 32'(fb_addr < 17'd76800), 32'd1);

        e.x      = 10'(xi);
        e.y      = 10'(yi);
        e.hs     = !(xi >= 656 && xi < 752);
        e.vs     = !(yi == 490 || yi == 491);
        e.act    = (xi < 640 && yi < 480);
        e.primed = primed;
        x = e.x; y = e.y;
        hsync_in = e.hs; vsync_in = e.vs; in_active_area = e.act;
        if (xi == 799 && yi == 479) primed = 1'b1;
        @(posedge clock_25mhz);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;
        @(negedge clock_25mhz);
    endtask

    task automatic drive_line(input int yy, input bit full);
        if (full) begin
            for (int xx = 0; xx < 800; xx++) step(xx, yy);
        end else begin
            step(0, yy);
            repeat (3) step(int'($urandom_range(638, 1)), yy);
            step(639, yy); step(640, yy); step(655, yy); step(656, yy);
            step(751, yy); step(752, yy); step(799, yy);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_rgb", 32'({red, green, blue}), 32'h0);
        chk("rst_hsync", 32'(hsync), 32'h1);
        chk("rst_vsync", 32'(vsync), 32'h1);
        chk("rst_rd_en", 32'(fb_rd_en), 32'h0);
        chk("rst_addr", 32'(fb_addr), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #2 check_reset_outputs();
        @(negedge clock_25mhz);
        reset = 1'b0;
        model_reset();

        // Release mid-frame: must stay black until the end-of-frame reload.
        for (int yy = 100; yy < 104; yy++) drive_line(yy, 1'b0);
        for (int yy = 470; yy < 525; yy++) drive_line(yy, 1'b0);

        // Frame 1: hashed RAM contents, a few fully scanned lines.
        fs_seen = 0;
        for (int yy = 0; yy < 525; yy++)
            drive_line(yy, (yy < 4) || (yy == 479) || (yy == 241));
        chk("frame1_pulses", 32'(fs_seen), 32'd1);

        // Frame 2: constant 0xE3 bytes; mid-line asynchronous reset.
        ram_mode = 1;
        fs_seen = 0;
        for (int yy = 0; yy < 200; yy++) drive_line(yy, yy < 2);
        for (int xx = 0; xx <= 300; xx++) step(xx, 200);
        chk("pre_reset_rgb", 32'({red, green, blue}), 32'hF0F);
        #5 reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clock_25mhz);
        check_reset_outputs();
        reset = 1'b0;
        model_reset();
        for (int xx = 301; xx < 800; xx++) step(xx, 200);
        for (int yy = 201; yy < 525; yy++) drive_line(yy, yy == 479);

        // Frame 3: recovery after the reload, first address back at 0.
        fs_seen = 0;
        for (int yy = 0; yy < 3; yy++) drive_line(yy, 1'b1);
        chk("frame3_pulses", 32'(fs_seen), 32'd1);
        step(0, 3); step(1, 3); step(2, 3); step(3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel fetch stage that sits directly downstream of `vga_driver`. It turns the driver's 640x480 scan position into read addresses for a 320x240 RGB332 framebuffer, with each source pixel doubled 2x2. It expands the returned byte to 4:4:4 RGB and delays `hsync`/`vsync`/`in_active_area` so that sync and colour reach the DAC pins aligned.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line.
- `V_ACTIVE`, 480, visible lines per frame.
- `H_TOTAL`, 800, pixel clocks per line (last x = `H_TOTAL`-1).
- `FB_WIDTH`, 320, framebuffer pixels per row.
- `ADDR_WIDTH`, 17, framebuffer address width.

Ports:
- `clock_25mhz`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `x`, `y`  in  10 each  scan position from `vga_driver`.
- `hsync_in`, `vsync_in`  in  1 each  sync outputs of `vga_driver` (active-low).
- `in_active_area`  in  1  driver's visible-region flag.
- `fb_addr`  out  `ADDR_WIDTH`  framebuffer read address.
- `fb_rd_en`  out  1  read strobe.
- `fb_data`  in  8  RGB332 byte, valid exactly 1 cycle after `fb_addr`/`fb_rd_en`.
- `red`, `green`, `blue`  out  4 each  pixel colour.
- `hsync`, `vsync`  out  1 each  delayed syncs (active-low).
- `frame_start`  out  1  one-cycle pulse aligned with pixel (0,0) at the outputs.

## Operation
- **Row base register `row_base`** (`ADDR_WIDTH` bits):
  - Loaded with 0 on the cycle x=`H_TOTAL`-1, y=`V_ACTIVE`-1.
  - Incremented by `FB_WIDTH` on the cycle x=`H_TOTAL`-1 when y is odd and y<`V_ACTIVE`-1.
  - Holds otherwise.
  - Result: source row = y[9:1]. No multiplier is permitted.
- **Stage A** (registered, 1 cycle after input):
  - `fb_addr` ← `row_base` + x[9:1].
  - `fb_rd_en` ← `in_active_area`.
  - When `in_active_area`=0, `fb_addr` holds its last value.
- **Stage B**: the RAM returns `fb_data`. The block only carries delayed flags through this stage.
- **Stage C** (registered output):
  - If the delayed active flag is 1: `red`={d[7:5],d[7]}, `green`={d[4:2],d[4]}, `blue`={d[1:0],d[1:0]}.
  - Else: all colour outputs are 0. Blanking must be black.
- `hsync_in`, `vsync_in` and `in_active_area` pass through a 3-deep shift register, so they emerge aligned with the colour.
- `frame_start`: the condition (x=0 && y=0) is delayed 3 cycles.
- **Reset (asynchronous)**:
  - `row_base`=0, `fb_addr`=0, `fb_rd_en`=0, colour outputs 0, `frame_start`=0.
  - Sync pipeline and `hsync`/`vsync` are reset to 1 (inactive); active-flag pipeline to 0.
  - Deasserting reset mid-frame: outputs are black until the next (`H_TOTAL`-1, `V_ACTIVE`-1) reload. Rows fetched before that reload may be misaddressed. This is accepted and is not an error.

## Timing
- Input-to-output latency is 3 cycles for colour, syncs, active flag and `frame_start`.
- `fb_addr` and `fb_rd_en` change 1 cycle after the matching x/y.
- The RAM must return data on the next edge. There is no handshake and no stall.
- Within one active line:
  - `fb_addr` advances by 1 every 2 cycles.
  - x=0..639 produces addresses `row_base`+0..319, each repeated twice.
- Each row base is used for two consecutive lines (y=2k and 2k+1).
- Last visible pixel (639,479) reads address 76799. The maximum address never exceeds 76799.
- Row base increment and reload are both evaluated at x=`H_TOTAL`-1 and are mutually exclusive. Reload has priority.

## Configuration
- Macro `VGA_PIXEL_FETCH_BORDER_EN`:
  - **Defined:** the outermost visible ring (x=0, x=639, y=0, y=479) is forced to white (F,F,F) at stage C. `fb_rd_en` is still asserted there, and the fetched data is discarded.
  - **Undefined:** the border shows framebuffer data like every other pixel.
- Latency is identical in both builds.

## Test plan
- **Reset:** assert `reset` mid-line.
  - Immediately, asynchronously, and without waiting for a clock edge: colour outputs are 0, `hsync`=`vsync`=1, `fb_rd_en`=0, `fb_addr`=0.
  - After release: outputs stay black until after the first (799,479) reload.
- **Addressing:** drive the driver model for a full frame, and also feed x/y directly.
  - At y=0 and y=1, x=0..639, `fb_addr` = 0,0,1,1,…,319,319.
  - At y=2, `fb_addr` starts at 320.
  - At (639,479), `fb_addr` = 76799.
- **Colour expansion:** RAM model returns 8'hE3 for every address.
  - Active region: `red`=F, `green`=0, `blue`=F.
  - Blanking: all colour outputs are 0.
- **Alignment:** the first visible pixel's colour, `hsync` and `vsync` edges and `frame_start` all appear exactly 3 cycles after the corresponding input.
  - `frame_start` pulses exactly once per 420000 cycles.
- **Border:** build with `VGA_PIXEL_FETCH_BORDER_EN` and `fb_data`=0.
  - Pixels (0,5), (639,5), (5,0) and (5,479) are F,F,F.
  - Pixel (5,5) is 0,0,0.
- **Frame wrap:** across two consecutive frames, the first address of frame 2 is 0. No address reaches 76800 or above.
